// File: rtl/spi_flash_responder.sv
// SPI flash read responder: 0x03 single-bit and 0x6B quad-output reads
// served from an external byte store, all SPI inputs synchronised to clk.
module spi_flash_responder #(
  parameter int MEM_ADDR_BITS = 12,
  parameter int DUMMY_CYCLES  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     spi_cs_n,
  input  logic                     spi_sclk,
  input  logic [3:0]               spi_io_in,
  output logic [3:0]               spi_io_out,
  output logic [3:0]               spi_io_oe,
  output logic [MEM_ADDR_BITS-1:0] rom_addr,
  input  logic [7:0]               rom_data,
  output logic                     busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_IGNORE
  } state_e;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_QUAD = 8'h6B;
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
  localparam logic [MEM_ADDR_BITS-1:0] ADDR_ONE = MEM_ADDR_BITS'(1);

  logic       cs_s1_q, cs_s2_q;
  logic       sck_s1_q, sck_s2_q, sck_prev_q;
  logic [3:0] io_s1_q, io_s2_q;
  logic [1:0] vld_q;

  state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  obuf_q, obuf_d;
  logic [3:0]  io_out_q, io_out_d;
  logic [3:0]  oe_q, oe_d;
  logic [MEM_ADDR_BITS-1:0] rom_addr_q, rom_addr_d;
  logic        armed_q, armed_d;

  logic rise, fall, quad, io0;
  logic unused_io;

  assign rise = sck_s2_q & ~sck_prev_q;
  assign fall = ~sck_s2_q & sck_prev_q;
  assign io0  = io_s2_q[0];
  assign quad = (cmd_q == CMD_QUAD);
  assign unused_io = ^io_s2_q[3:1];

  assign spi_io_out = io_out_q;
  assign spi_io_oe  = oe_q;
  assign rom_addr   = rom_addr_q;
  assign busy       = (state_q != S_IDLE);

  // Two-flop synchronisers plus edge history; vld marks real samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_s1_q    <= 1'b1;
      cs_s2_q    <= 1'b1;
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_prev_q <= 1'b0;
      io_s1_q    <= 4'h0;
      io_s2_q    <= 4'h0;
      vld_q      <= 2'b00;
    end else begin
      cs_s1_q    <= spi_cs_n;
      cs_s2_q    <= cs_s1_q;
      sck_s1_q   <= spi_sclk;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      io_s1_q    <= spi_io_in;
      io_s2_q    <= io_s1_q;
      vld_q      <= {vld_q[0], 1'b1};
    end
  end

  // Protocol state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      cmd_q      <= 8'd0;
      addr_q     <= 24'd0;
      obuf_q     <= 8'd0;
      io_out_q   <= 4'h0;
      oe_q       <= 4'h0;
      rom_addr_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      obuf_q     <= obuf_d;
      io_out_q   <= io_out_d;
      oe_q       <= oe_d;
      rom_addr_q <= rom_addr_d;
      armed_q    <= armed_d;
    end
  end

  // Next state: CS release wins; a transaction only starts once
  // a genuine CS-high has been seen since reset
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    obuf_d     = obuf_q;
    io_out_d   = io_out_q;
    oe_d       = oe_q;
    rom_addr_d = rom_addr_q;
    armed_d    = armed_q | (vld_q[1] & cs_s2_q);

    if (state_q != S_IDLE && cs_s2_q) begin
      state_d  = S_IDLE;
      cnt_d    = 8'd0;
      oe_d     = 4'h0;
      io_out_d = 4'h0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          oe_d     = 4'h0;
          io_out_d = 4'h0;
          if (armed_q && !cs_s2_q) begin
            state_d = S_CMD;
            cnt_d   = 8'd0;
            cmd_d   = 8'd0;
            addr_d  = 24'd0;
            obuf_d  = 8'd0;
          end
        end
        S_CMD: begin
          if (rise) begin
            cmd_d = {cmd_q[6:0], io0};
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd7) begin
              cnt_d = 8'd0;
              if (cmd_d == CMD_READ || cmd_d == CMD_QUAD)
                state_d = S_ADDR;
              else
                state_d = S_IGNORE;
            end
          end
        end
        S_ADDR: begin
          if (rise) begin
            addr_d = {addr_q[22:0], io0};
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q == 8'd23) begin
              cnt_d      = 8'd0;
              rom_addr_d = addr_d[MEM_ADDR_BITS-1:0];
              if (quad && DUMMY_CYCLES > 0)
                state_d = S_DUMMY;
              else
                state_d = S_DATA;
            end
          end
        end
        S_DUMMY: begin
          oe_d = 4'h0;
          if (rise) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == DUMMY_LAST) begin
              cnt_d   = 8'd0;
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (fall) begin
            if (cnt_q == 8'd0) begin
              rom_addr_d = rom_addr_q + ADDR_ONE;
              cnt_d      = 8'd1;
            end
            if (quad) begin
              oe_d = 4'hF;
              if (cnt_q == 8'd0) begin
                io_out_d = rom_data[7:4];
                obuf_d   = {rom_data[3:0], 4'h0};
              end else begin
                io_out_d = obuf_q[7:4];
                obuf_d   = {obuf_q[3:0], 4'h0};
                cnt_d    = 8'd0;
              end
            end else begin
              oe_d = 4'b0010;
              if (cnt_q == 8'd0) begin
                io_out_d = {2'b00, rom_data[7], 1'b0};
                obuf_d   = {rom_data[6:0], 1'b0};
              end else begin
                io_out_d = {2'b00, obuf_q[7], 1'b0};
                obuf_d   = {obuf_q[6:0], 1'b0};
                cnt_d    = (cnt_q == 8'd7) ? 8'd0
                                           : cnt_q + 8'd1;
              end
            end
          end
        end
        S_IGNORE: begin
          oe_d     = 4'h0;
          io_out_d = 4'h0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: SPI initiator model, byte-store model
// and expected read data computed from address arithmetic.
module tb_spi_flash_responder;

  logic        clk;
  logic        rst_n;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic [3:0]  spi_io_in;
  logic [3:0]  spi_io_out;
  logic [3:0]  spi_io_oe;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic        busy;

  logic [7:0] mem [0:4095];

  int vecs;
  int errs;
  int h;
  bit quiet_win;

  spi_flash_responder #(
    .MEM_ADDR_BITS(12),
    .DUMMY_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi_cs_n(spi_cs_n),
    .spi_sclk(spi_sclk),
    .spi_io_in(spi_io_in),
    .spi_io_out(spi_io_out),
    .spi_io_oe(spi_io_oe),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // byte store: data valid one clk after the address
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // every cycle: undriven bits read 0; quiet windows never drive
  always @(negedge clk) begin
    if (rst_n) begin
      chk("undriven_zero",
          {28'd0, spi_io_out & ~spi_io_oe}, 32'd0);
      if (quiet_win)
        chk("quiet_oe", {28'd0, spi_io_oe}, 32'd0);
    end
  end

  task automatic pulse();
    spi_sclk = 1'b1;
    #h;
    spi_sclk = 1'b0;
  endtask

  task automatic sbit(input logic b);
    spi_io_in[0] = b;
    spi_io_in[3:1] = 3'($urandom);
    #h;
    chk("hdr_oe", {28'd0, spi_io_oe}, 32'd0);
    pulse();
  endtask

  task automatic shift(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sbit(v[i]);
  endtask

  task automatic idle_clks(input int n);
    for (int i = 0; i < n; i++) begin
      #h;
      chk("idle_oe", {28'd0, spi_io_oe}, 32'd0);
      pulse();
    end
  endtask

  task automatic cs_begin();
    @(posedge clk);
    #3;
    h = 10 * $urandom_range(4, 7);
    spi_cs_n = 1'b0;
    #h;
  endtask

  task automatic cs_end();
    #h;
    spi_cs_n = 1'b1;
    repeat (4) @(posedge clk);
    quiet_win = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  // expected byte k of a read starting at a: mem[(a + k) mod 4096]
  task automatic read_data(input int nb, input bit quad,
                           input logic [23:0] a,
                           output logic [31:0] cap);
    logic [11:0] ix;
    logic [7:0]  e;
    logic [3:0]  nib;
    cap = 32'd0;
    quiet_win = 1'b0;
    for (int k = 0; k < nb; k++) begin
      ix = a[11:0] + 12'(k);
      e  = mem[ix];
      if (quad) begin
        for (int n = 0; n < 2; n++) begin
          #h;
          nib = (n == 0) ? e[7:4] : e[3:0];
          chk("quad_io", {28'd0, spi_io_out}, {28'd0, nib});
          chk("quad_oe", {28'd0, spi_io_oe}, 32'hF);
          cap = {cap[27:0], spi_io_out};
          pulse();
        end
      end else begin
        for (int b = 7; b >= 0; b--) begin
          #h;
          chk("single_io", {28'd0, spi_io_out},
              {29'd0, e[b], 1'b0} << 0);
          chk("single_oe", {28'd0, spi_io_oe}, 32'h2);
          cap = {cap[30:0], spi_io_out[1]};
          pulse();
        end
      end
    end
  endtask

  task automatic xfer(input logic [7:0] cmd,
                      input logic [23:0] a,
                      input int nb,
                      output logic [31:0] cap);
    cap = 32'd0;
    cs_begin();
    shift({24'd0, cmd}, 8);
    if (cmd == 8'h03 || cmd == 8'h6B) begin
      shift({8'd0, a}, 24);
      if (cmd == 8'h6B) idle_clks(8);
      read_data(nb, cmd == 8'h6B, a, cap);
    end else begin
      idle_clks(16);
      chk("ignore_busy", {31'd0, busy}, 32'd1);
    end
    cs_end();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cap;
    logic [23:0] a;
    logic [7:0]  c;
    vecs = 0;
    errs = 0;
    h = 50;
    quiet_win = 1'b1;
    rst_n = 1'b0;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_io_in = 4'h0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h010] = 8'hA5;
    mem[12'h011] = 8'h3C;
    mem[12'h020] = 8'h5E;
    mem[12'hFFF] = 8'h81;
    mem[12'h000] = 8'h7E;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe", {28'd0, spi_io_oe}, 32'd0);
    chk("rst_io", {28'd0, spi_io_out}, 32'd0);
    chk("rst_addr", {20'd0, rom_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);

    xfer(8'h03, 24'h000010, 2, cap);
    chk("single_pin", cap, 32'h0000A53C);

    xfer(8'h6B, 24'h000020, 1, cap);
    chk("quad_pin", cap, 32'h0000005E);

    xfer(8'h03, 24'h000FFF, 2, cap);
    chk("wrap_pin", cap, 32'h0000817E);

    xfer(8'h9F, 24'h0, 0, cap);
    cs_begin();
    shift(32'h9F, 8);
    idle_clks(32);
    cs_end();
    xfer(8'h03, 24'hAB0123, 3, cap);

    cs_begin();
    shift(32'h03, 8);
    shift(32'h5A5, 12);
    spi_cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_oe", {28'd0, spi_io_oe}, 32'd0);
    repeat (10) @(posedge clk);
    xfer(8'h03, 24'h000010, 2, cap);
    chk("post_abort", cap, 32'h0000A53C);

    cs_begin();
    shift(32'h03, 8);
    shift(32'h000234, 24);
    read_data(1, 1'b0, 24'h000234, cap);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_oe", {28'd0, spi_io_oe}, 32'd0);
    chk("mid_rst_io", {28'd0, spi_io_out}, 32'd0);
    chk("mid_rst_addr", {20'd0, rom_addr}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    quiet_win = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #3;
    idle_clks(16);
    chk("no_fresh_fall", {31'd0, busy}, 32'd0);
    cs_end();
    xfer(8'h6B, 24'h000FFF, 2, cap);
    chk("quad_wrap_pin", cap, 32'h0000817E);

    for (int t = 0; t < 25; t++) begin
      a = 24'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    c = 8'h03;
        2:       c = 8'h6B;
        default: c = 8'($urandom);
      endcase
      xfer(c, a, $urandom_range(1, 4), cap);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 Parameter MEM_ADDR_BITS, default 12: width of the backing-store address; higher address bits are ignored.
REQ-002 Parameter DUMMY_CYCLES, default 8: number of dummy SCLK cycles for command 0x6B.
REQ-003 clk  input  1: single clock; must be at least 6x the SPI SCLK frequency.
REQ-004 rst_n  input  1: reset, synchronous, active-low.
REQ-005 spi_cs_n  input  1: chip select from the SPI initiator, active-low.
REQ-006 spi_sclk  input  1: SPI clock from the initiator, mode 0 (idle low).
REQ-007 spi_io_in  input  4: io[3:0] as driven by the initiator; only io[0] carries command and address bits.
REQ-008 spi_io_out  output  4: data the responder drives onto io[3:0].
REQ-009 spi_io_oe  output  4: per-bit output enable for spi_io_out; 1 = responder drives.
REQ-010 rom_addr  output  MEM_ADDR_BITS: byte address to the backing store.
REQ-011 rom_data  input  8: backing-store byte, valid one clk after rom_addr changes.
REQ-012 busy  output  1: high while the state is not IDLE.

Function
REQ-013 spi_cs_n, spi_sclk and spi_io_in shall each pass through a 2-flop synchronizer; all logic uses only the synchronized copies.
- SCLK rise = sync sclk 0->1; SCLK fall = sync sclk 1->0.
REQ-014 States: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
REQ-015 IDLE -> CMD when synchronized cs_n goes low; clear the bit counter and shift registers.
REQ-016 CMD: on each SCLK rise, shift io[0] in MSB first; after 8 bits:
- 0x03 or 0x6B -> ADDR.
- any other value -> IGNORE.
REQ-017 ADDR: shift 24 address bits MSB first on SCLK rises; after the 24th bit, load rom_addr with addr[MEM_ADDR_BITS-1:0].
- 0x03 -> DATA.
- 0x6B -> DUMMY.
REQ-018 DUMMY: count DUMMY_CYCLES SCLK rises, then -> DATA; spi_io_oe stays 0.
REQ-019 DATA, single (0x03): on each SCLK fall drive the next bit of the current byte, MSB first, on io[1]; spi_io_oe = 4'b0010.
REQ-020 DATA, quad (0x6B): on each SCLK fall drive the next nibble on io[3:0], high nibble first; spi_io_oe = 4'b1111.
REQ-021 The first data bit or nibble is driven on the first SCLK fall after entering DATA.
REQ-022 At byte start, latch rom_data into the output shift register, then increment rom_addr so the next byte is prefetched before its first fall.
REQ-023 rom_addr wraps from 2^MEM_ADDR_BITS-1 to 0; reads continue with no limit until CS rises.
REQ-024 IGNORE: outputs tristated (spi_io_oe = 0), inputs ignored, until CS rises.
REQ-025 Synchronized cs_n high in any state -> IDLE on the next clk, spi_io_oe = 0, with a partial byte or address discarded; this has priority over any simultaneous SCLK edge.
REQ-026 SCLK edges while in IDLE are ignored.
REQ-027 spi_io_out shall hold its value between falls; bits not enabled by spi_io_oe shall read 0.

Reset
REQ-028 rst_n low at a clk rise shall set: state IDLE, spi_io_oe = 0, spi_io_out = 0, rom_addr = 0, busy = 0, all counters and shift registers = 0, synchronizer flops = idle (cs_n 1, sclk 0).
REQ-029 Reset asserted mid-transaction aborts it; after release the block waits for a fresh cs_n fall, even if cs_n is already low.

Verification
REQ-030 Single read: CS low, cmd 0x03, addr 0x000010, rom[0x10]=0xA5, rom[0x11]=0x3C, 16 data clocks -> io[1] bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 with spi_io_oe = 4'b0010.
REQ-031 Quad read: cmd 0x6B, addr 0x000020, 8 dummy clocks, rom[0x20]=0x5E -> spi_io_oe 0 through the dummy clocks, then nibbles 0x5, 0xE on io[3:0] with spi_io_oe = 4'b1111.
REQ-032 Wrap: cmd 0x03, addr 0x000FFF (MEM_ADDR_BITS=12), 2 bytes -> rom[0xFFF] then rom[0x000].
REQ-033 Bad command: cmd 0x9F -> spi_io_oe stays 0 for 32 further clocks; after a CS high/low cycle, a 0x03 read succeeds.
REQ-034 Abort: CS raised after 12 address bits -> busy = 0 and spi_io_oe = 0 within 3 clk; the next full 0x03 transaction returns correct data.
REQ-035 Reset: rst_n low during DATA -> all outputs at reset values on the next clk; no drive until a new cs_n fall.
